// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared state, opcode and select encodings for the multi-cycle control FSM
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_REL  = 2'd1;
  localparam logic [1:0] PC_JALR = 2'd2;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  function automatic logic op_legal(input logic [6:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_LUI, OP_AUIPC, OP_BRANCH, OP_JAL, OP_JALR};
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles a request waits for ready and flags a timeout at MAX_WAIT
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic clear,
  input  logic req,
  input  logic ready,
  output logic timeout
);
  localparam int W = MAX_WAIT > 1 ? $clog2(MAX_WAIT + 1) : 1;
  logic [W-1:0] cnt;
  // Idle or completed cycles restart the count, so every new request starts from zero
  always_ff @(posedge clk)
    cnt <= (clear || !req || ready) ? '0 : cnt + 1'b1;
  assign timeout = (MAX_WAIT != 0) && req && !ready && (cnt == W'(MAX_WAIT - 1));
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle RV32I control sequencer with memory handshakes, traps and retire count
module mc_ctrl_fsm
  import core_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             system_reset,
  input  logic [31:0]      inst,
  input  logic             branch_cmp_output,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_WE,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic             wen,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);
  state_t st;
  logic [6:0] op;
  logic unused_inst;
  logic is_load, is_store, is_r, is_i, is_lui, is_auipc, is_branch, is_jal, is_jalr;
  logic mem_wait, mem_ready, timeout;
  logic act, in_ex, in_wb, alu_phase;

  assign op          = inst[6:0];
  assign unused_inst = ^inst[31:7];
  assign is_load     = op == OP_LOAD;
  assign is_store    = op == OP_STORE;
  assign is_r        = op == OP_R;
  assign is_i        = op == OP_I;
  assign is_lui      = op == OP_LUI;
  assign is_auipc    = op == OP_AUIPC;
  assign is_branch   = op == OP_BRANCH;
  assign is_jal      = op == OP_JAL;
  assign is_jalr     = op == OP_JALR;

  assign mem_wait  = st == ST_FETCH || st == ST_MEM;
  assign mem_ready = st == ST_FETCH ? imem_ready : dmem_ready;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk    (clk),
    .clear  (system_reset),
    .req    (mem_wait),
    .ready  (mem_ready),
    .timeout(timeout)
  );

  always_ff @(posedge clk) begin
    if (system_reset) begin
      st         <= ST_FETCH;
      trap_cause <= CAUSE_NONE;
      instret    <= '0;
    end else begin
      case (st)
        ST_FETCH:
          if (imem_ready) st <= ST_DECODE;
          else if (timeout) begin
            st         <= ST_TRAP;
            trap_cause <= CAUSE_IMEM;
          end
        ST_DECODE:
          if (op_legal(op)) st <= ST_EXEC;
          else begin
            st         <= ST_TRAP;
            trap_cause <= CAUSE_ILLEGAL;
          end
        ST_EXEC:
          if (is_branch) begin
            st      <= ST_FETCH;
            instret <= instret + 1'b1;
          end else st <= (is_load || is_store) ? ST_MEM : ST_WB;
        ST_MEM:
          if (dmem_ready) begin
            st <= is_store ? ST_FETCH : ST_WB;
            if (is_store) instret <= instret + 1'b1;
          end else if (timeout) begin
            st         <= ST_TRAP;
            trap_cause <= CAUSE_DMEM;
          end
        ST_WB: begin
          st      <= ST_FETCH;
          instret <= instret + 1'b1;
        end
        ST_TRAP: st <= ST_TRAP;
        default: st <= ST_FETCH;
      endcase
    end
  end

  // Reset suppresses every strobe in its own cycle, even mid-handshake
  assign act       = !system_reset;
  assign in_ex     = act && st == ST_EXEC;
  assign in_wb     = act && st == ST_WB;
  // Operand selects stay stable from EXEC through WB so the ALU result holds for MEM and WB
  assign alu_phase = act && (st == ST_EXEC || st == ST_MEM || st == ST_WB);

  assign imem_req  = act && st == ST_FETCH;
  assign ir_we     = imem_req && imem_ready;
  assign dmem_req  = act && st == ST_MEM;
  assign dmem_WE   = dmem_req && is_store;
  assign pc_we     = in_wb || (in_ex && is_branch) || (dmem_WE && dmem_ready);
  assign pc_sel    = (in_ex && is_branch && branch_cmp_output) ? PC_REL :
                     (in_wb && is_jal)  ? PC_REL :
                     (in_wb && is_jalr) ? PC_JALR : PC_SEQ;
  assign alu_a_sel = alu_phase && is_auipc;
  assign alu_b_sel = alu_phase && (is_i || is_load || is_store || is_lui || is_auipc) && !is_r;
  assign wen       = in_wb;
  assign wb_sel    = !in_wb ? WB_MEM : is_load ? WB_MEM : (is_jal || is_jalr) ? WB_PC4 : WB_ALU;
  assign trap      = st == ST_TRAP;
  assign state     = st;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: table-driven per-cycle vectors plus directed trap, reset and watchdog sequences
module tb_mc_ctrl_fsm;
  logic        clk = 1'b0;
  logic        system_reset = 1'b1;
  logic [31:0] inst = '0;
  logic        branch_cmp_output = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, dmem_req, dmem_WE, ir_we, pc_we, alu_a_sel, alu_b_sel, wen, trap;
  logic [1:0]  pc_sel, wb_sel, trap_cause;
  logic [31:0] instret;
  logic [2:0]  state;
  logic [11:0] obs;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h00002083;
  localparam logic [31:0] I_BEQ  = 32'h00000063;
  localparam logic [31:0] I_JALR = 32'h000080E7;
  localparam logic [31:0] I_SW   = 32'h00102023;
  localparam logic [31:0] I_JAL  = 32'h000000EF;
  localparam logic [31:0] I_AUI  = 32'h00000097;
  localparam logic [31:0] I_LUI  = 32'h000000B7;
  localparam logic [31:0] I_ADD  = 32'h00000033;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  // {imem_req,dmem_req,dmem_WE, ir_we,pc_we, pc_sel, alu_a,alu_b, wen, wb_sel}
  localparam logic [11:0] E_FETCH = 12'b100_10_00_00_0_00;
  localparam logic [11:0] E_ZERO  = 12'b000_00_00_00_0_00;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MAX_WAIT(4), .CNT_W(32)) dut (
    .clk              (clk),
    .system_reset     (system_reset),
    .inst             (inst),
    .branch_cmp_output(branch_cmp_output),
    .imem_ready       (imem_ready),
    .dmem_ready       (dmem_ready),
    .imem_req         (imem_req),
    .dmem_req         (dmem_req),
    .dmem_WE          (dmem_WE),
    .ir_we            (ir_we),
    .pc_we            (pc_we),
    .pc_sel           (pc_sel),
    .alu_a_sel        (alu_a_sel),
    .alu_b_sel        (alu_b_sel),
    .wen              (wen),
    .wb_sel           (wb_sel),
    .trap             (trap),
    .trap_cause       (trap_cause),
    .instret          (instret),
    .state            (state)
  );

  assign obs = {imem_req, dmem_req, dmem_WE, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, wen, wb_sel};

  typedef struct {
    logic [31:0] inst;
    logic        cmp, ir, dr;
    logic [2:0]  st;
    logic [11:0] exp;
    int          ret;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] i, input logic c, input logic r, input logic d,
                     input logic [2:0] s, input logic [11:0] e, input int n);
    vec_t v;
    v.inst = i; v.cmp = c; v.ir = r; v.dr = d; v.st = s; v.exp = e; v.ret = n;
    vq.push_back(v);
  endtask

  task automatic fd(input logic [31:0] i, input int n);
    add(i, 0, 1, 0, 3'd0, E_FETCH, n);
    add(i, 0, 0, 0, 3'd1, E_ZERO, n);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    fd(I_ADDI, 0);
    add(I_ADDI, 0, 0, 0, 3'd2, 12'b000_00_00_01_0_00, 0);
    add(I_ADDI, 0, 0, 0, 3'd4, 12'b000_01_00_01_1_01, 0);
    fd(I_LW, 1);
    add(I_LW, 0, 0, 0, 3'd2, 12'b000_00_00_01_0_00, 1);
    for (int k = 0; k < 3; k++) add(I_LW, 0, 0, 0, 3'd3, 12'b010_00_00_01_0_00, 1);
    add(I_LW, 0, 0, 1, 3'd3, 12'b010_00_00_01_0_00, 1);
    add(I_LW, 0, 0, 0, 3'd4, 12'b000_01_00_01_1_00, 1);
    fd(I_BEQ, 2);
    add(I_BEQ, 1, 0, 0, 3'd2, 12'b000_01_01_00_0_00, 2);
    fd(I_BEQ, 3);
    add(I_BEQ, 0, 0, 0, 3'd2, 12'b000_01_00_00_0_00, 3);
    fd(I_JALR, 4);
    add(I_JALR, 0, 0, 0, 3'd2, E_ZERO, 4);
    add(I_JALR, 0, 0, 0, 3'd4, 12'b000_01_10_00_1_10, 4);
    add(I_SW, 0, 0, 0, 3'd0, 12'b100_00_00_00_0_00, 5);
    fd(I_SW, 5);
    add(I_SW, 0, 0, 0, 3'd2, 12'b000_00_00_01_0_00, 5);
    add(I_SW, 0, 1, 0, 3'd3, 12'b011_00_00_01_0_00, 5);
    add(I_SW, 0, 0, 1, 3'd3, 12'b011_01_00_01_0_00, 5);
    fd(I_JAL, 6);
    add(I_JAL, 0, 0, 0, 3'd2, E_ZERO, 6);
    add(I_JAL, 0, 0, 0, 3'd4, 12'b000_01_01_00_1_10, 6);
    fd(I_AUI, 7);
    add(I_AUI, 0, 0, 0, 3'd2, 12'b000_00_00_11_0_00, 7);
    add(I_AUI, 0, 0, 0, 3'd4, 12'b000_01_00_11_1_01, 7);
    fd(I_LUI, 8);
    add(I_LUI, 0, 0, 0, 3'd2, 12'b000_00_00_01_0_00, 8);
    add(I_LUI, 0, 0, 0, 3'd4, 12'b000_01_00_01_1_01, 8);
    fd(I_ADD, 9);
    add(I_ADD, 0, 0, 0, 3'd2, E_ZERO, 9);
    add(I_ADD, 0, 0, 0, 3'd4, 12'b000_01_00_00_1_01, 9);
    add(I_ADD, 0, 0, 1, 3'd0, 12'b100_00_00_00_0_00, 10);

    #1;
    chk("reset_cycle_strobes", {20'd0, obs}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    system_reset = 1'b0;
    chk("reset_state", {29'd0, state}, 32'd0);
    chk("reset_trap", {31'd0, trap}, 32'd0);
    chk("reset_instret", instret, 32'd0);

    foreach (vq[k]) begin
      inst = vq[k].inst;
      branch_cmp_output = vq[k].cmp;
      imem_ready = vq[k].ir;
      dmem_ready = vq[k].dr;
      #1;
      chk($sformatf("v%0d_out", k), {20'd0, obs}, {20'd0, vq[k].exp});
      chk($sformatf("v%0d_state", k), {29'd0, state}, {29'd0, vq[k].st});
      chk($sformatf("v%0d_instret", k), instret, vq[k].ret);
      cyc();
    end

    // Illegal opcode traps; TRAP ignores ready and only reset leaves it
    branch_cmp_output = 1'b0;
    dmem_ready = 1'b0;
    inst = I_BAD;
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    chk("bad_decode_state", {29'd0, state}, 32'd1);
    cyc();
    chk("bad_trap_state", {29'd0, state}, 32'd5);
    chk("bad_trap_flag", {31'd0, trap}, 32'd1);
    chk("bad_trap_cause", {30'd0, trap_cause}, 32'd1);
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("trap_quiet%0d", k), {20'd0, obs}, 32'd0);
      cyc();
    end
    chk("trap_held_cause", {30'd0, trap_cause}, 32'd1);
    chk("trap_instret_frozen", instret, 32'd10);
    dmem_ready = 1'b0;
    system_reset = 1'b1;
    #1;
    chk("trap_reset_strobes", {20'd0, obs}, 32'd0);
    cyc();
    system_reset = 1'b0;
    chk("post_trap_state", {29'd0, state}, 32'd0);
    chk("post_trap_flag", {31'd0, trap}, 32'd0);
    chk("post_trap_cause", {30'd0, trap_cause}, 32'd0);
    chk("post_trap_instret", instret, 32'd0);
    #1;
    chk("post_trap_imem_req", {31'd0, imem_req}, 32'd1);
    system_reset = 1'b1;
    #1;
    chk("reset_mid_fetch_irwe", {31'd0, ir_we}, 32'd0);
    cyc();
    system_reset = 1'b0;
    chk("reset_mid_fetch_state", {29'd0, state}, 32'd0);

    // IMEM watchdog: four cycles without ready traps, ready on the fourth succeeds
    imem_ready = 1'b0;
    inst = I_LW;
    repeat (3) cyc();
    chk("imem_wait3_state", {29'd0, state}, 32'd0);
    cyc();
    chk("imem_to_state", {29'd0, state}, 32'd5);
    chk("imem_to_cause", {30'd0, trap_cause}, 32'd2);
    system_reset = 1'b1;
    cyc();
    system_reset = 1'b0;
    repeat (3) cyc();
    imem_ready = 1'b1;
    #1;
    chk("imem_late_irwe", {31'd0, ir_we}, 32'd1);
    cyc();
    imem_ready = 1'b0;
    chk("imem_late_state", {29'd0, state}, 32'd1);
    chk("imem_late_trap", {31'd0, trap}, 32'd0);

    // DMEM watchdog on a load
    cyc();
    cyc();
    chk("dmem_enter_state", {29'd0, state}, 32'd3);
    repeat (3) cyc();
    chk("dmem_wait3_state", {29'd0, state}, 32'd3);
    cyc();
    chk("dmem_to_state", {29'd0, state}, 32'd5);
    chk("dmem_to_cause", {30'd0, trap_cause}, 32'd3);
    chk("dmem_to_instret", instret, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
